// File: rtl/simp_bus_pkg.sv
// simp_bus_pkg: shared types and constants for the simple-bus bridge.
//   state_t     : bridge FSM states (IDLE, BEAT, RESP)
//   SB_LANES    : byte lanes per CPU word
//   LANE_IDX_W  : width of a lane index
//   BYTE_W      : width of one peripheral beat
package simp_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEAT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int SB_LANES   = 4;
   localparam int LANE_IDX_W = 2;
   localparam int BYTE_W     = 8;

endpackage

// File: rtl/simp_bus_lane_sel.sv
// simp_bus_lane_sel: combinational finder for the next lane to service.
// Ports:
//   mask     in  byte-lane enables
//   idx      in  lane just serviced (ignored when first = 1)
//   first    in  1 = search from lane 0, 0 = search above idx
//   next_idx out lowest qualifying set lane
//   found    out a qualifying lane exists
module simp_bus_lane_sel
   import simp_bus_pkg::*;
(
   input  logic [SB_LANES-1:0]   mask,
   input  logic [LANE_IDX_W-1:0] idx,
   input  logic                  first,
   output logic [LANE_IDX_W-1:0] next_idx,
   output logic                  found
);

   always_comb begin
      found    = 1'b0;
      next_idx = '0;
      for (int i = 0; i < SB_LANES; i++) begin
         if (!found && mask[i] && (first || (LANE_IDX_W'(i) > idx))) begin
            found    = 1'b1;
            next_idx = LANE_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/simp_bus_bridge.sv
// simp_bus_bridge: initiator side of the 8-bit simple peripheral bus.
// Splits 32-bit CPU commands into one-byte beats and reassembles read data.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_wr, cmd_addr, cmd_data,
//   cmd_mask                         command fields (addr[1:0] ignored)
//   rsp_valid, rsp_data              one-cycle read response
//   sb_adr, sb_din, sb_wr_en         registered peripheral drive
//   sb_dout                          combinational peripheral read byte
// Build option: define SIMP_BUS_RD_ALL_EN to make every read fetch all
// four lanes regardless of cmd_mask (writes still follow the mask).
module simp_bus_bridge
   import simp_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int SB_ADR_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_wr,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [31:0]         cmd_data,
   input  logic [3:0]          cmd_mask,
   output logic                rsp_valid,
   output logic [31:0]         rsp_data,
   output logic [SB_ADR_W-1:0] sb_adr,
   output logic [7:0]          sb_din,
   input  logic [7:0]          sb_dout,
   output logic                sb_wr_en
);

   state_t                  state_reg, state_next;
   logic [SB_ADR_W-1:0]     base_reg, base_next;
   logic                    wr_reg, wr_next;
   logic [31:0]             data_reg, data_next;
   logic [SB_LANES-1:0]     mask_reg, mask_next;
   logic [LANE_IDX_W-1:0]   idx_reg, idx_next;
   logic [31:0]             rsp_data_reg, rsp_data_next;
   logic [SB_ADR_W-1:0]     sb_adr_reg, sb_adr_next;
   logic [7:0]              sb_din_reg, sb_din_next;
   logic                    sb_wr_en_reg, sb_wr_en_next;

   logic [SB_LANES-1:0]     acc_mask;
   logic [SB_LANES-1:0]     sel_mask;
   logic [LANE_IDX_W-1:0]   sel_idx;
   logic                    sel_found;
   logic [SB_ADR_W-1:0]     acc_base;

`ifdef SIMP_BUS_RD_ALL_EN
   assign acc_mask = cmd_wr ? cmd_mask : 4'b1111;
`else
   assign acc_mask = cmd_mask;
`endif

   // Word-aligned peripheral base; the lane index fills the low two bits.
   assign acc_base = cmd_addr[SB_ADR_W-1:0] & ~SB_ADR_W'(3);

   // One finder serves both the accept search and the per-beat search.
   assign sel_mask = (state_reg == IDLE) ? acc_mask : mask_reg;

   simp_bus_lane_sel u_lane_sel (
      .mask     (sel_mask),
      .idx      (idx_reg),
      .first    (state_reg == IDLE),
      .next_idx (sel_idx),
      .found    (sel_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         base_reg     <= '0;
         wr_reg       <= 1'b0;
         data_reg     <= '0;
         mask_reg     <= '0;
         idx_reg      <= '0;
         rsp_data_reg <= '0;
         sb_adr_reg   <= '0;
         sb_din_reg   <= '0;
         sb_wr_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         base_reg     <= base_next;
         wr_reg       <= wr_next;
         data_reg     <= data_next;
         mask_reg     <= mask_next;
         idx_reg      <= idx_next;
         rsp_data_reg <= rsp_data_next;
         sb_adr_reg   <= sb_adr_next;
         sb_din_reg   <= sb_din_next;
         sb_wr_en_reg <= sb_wr_en_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      base_next     = base_reg;
      wr_next       = wr_reg;
      data_next     = data_reg;
      mask_next     = mask_reg;
      idx_next      = idx_reg;
      rsp_data_next = rsp_data_reg;
      sb_adr_next   = sb_adr_reg;
      sb_din_next   = sb_din_reg;
      sb_wr_en_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               base_next = acc_base;
               wr_next   = cmd_wr;
               data_next = cmd_data;
               mask_next = acc_mask;
               if (!cmd_wr)
                  rsp_data_next = '0;
               if (sel_found) begin
                  // Drive the first beat's bus values on the entry edge.
                  state_next    = BEAT;
                  idx_next      = sel_idx;
                  sb_adr_next   = acc_base | SB_ADR_W'(sel_idx);
                  sb_din_next   = cmd_data[{sel_idx, 3'b000} +: 8];
                  sb_wr_en_next = cmd_wr;
               end else begin
                  state_next = cmd_wr ? IDLE : RESP;
               end
            end
         end
         BEAT: begin
            if (!wr_reg)
               rsp_data_next[{idx_reg, 3'b000} +: 8] = sb_dout;
            if (sel_found) begin
               idx_next      = sel_idx;
               sb_adr_next   = base_reg | SB_ADR_W'(sel_idx);
               sb_din_next   = data_reg[{sel_idx, 3'b000} +: 8];
               sb_wr_en_next = wr_reg;
            end else begin
               state_next = wr_reg ? IDLE : RESP;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign cmd_ready = (state_reg == IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign rsp_data  = rsp_data_reg;
   assign sb_adr    = sb_adr_reg;
   assign sb_din    = sb_din_reg;
   assign sb_wr_en  = sb_wr_en_reg;

endmodule

// File: tb/tb_simp_bus_bridge.sv
// Testbench for simp_bus_bridge: table of commands with expected beat
// counts and read words, a byte-wide peripheral model, and scoreboard
// queues for write beats and read responses.
module tb_simp_bus_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic [3:0]  cmd_mask = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [2:0]  sb_adr;
   logic [7:0]  sb_din;
   logic [7:0]  sb_dout;
   logic        sb_wr_en;

   int total = 0;
   int bad   = 0;

   logic [10:0] wr_q[$];
   logic [31:0] rd_q[$];

   logic [7:0]  pmem [8];

   always #5 clk = ~clk;

   simp_bus_bridge #(.ADDR_W(32), .SB_ADR_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_wr    (cmd_wr),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .cmd_mask  (cmd_mask),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .sb_adr    (sb_adr),
      .sb_din    (sb_din),
      .sb_dout   (sb_dout),
      .sb_wr_en  (sb_wr_en)
   );

   // Peripheral model: combinational read, registered write.
   assign sb_dout = pmem[sb_adr];
   always @(posedge clk) begin
      if (sb_wr_en)
         pmem[sb_adr] <= sb_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard consumers.
   always @(negedge clk) begin
      if (rst_n && sb_wr_en) begin
         if (wr_q.size() == 0)
            check("unexpected_wr_beat", {21'd0, sb_adr, sb_din}, 32'hFFFF_FFFF);
         else
            check("wr_beat", {21'd0, sb_adr, sb_din}, {21'd0, wr_q.pop_front()});
      end
      if (rst_n && rsp_valid) begin
         if (rd_q.size() == 0)
            check("unexpected_rsp", rsp_data, 32'hFFFF_FFFF);
         else
            check("rsp_data", rsp_data, rd_q.pop_front());
      end
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      int          n;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic run_cmd(input int id, input vec_t v);
      int ready_k, rsp_k, rsp_cnt, wr_cnt;
      @(negedge clk);
      check("ready_before", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_wr    = v.wr;
      cmd_addr  = v.addr;
      cmd_data  = v.data;
      cmd_mask  = v.mask;
      if (v.wr) begin
         for (int l = 0; l < 4; l++)
            if (v.mask[l])
               wr_q.push_back({v.addr[2], l[1:0], v.data[8*l +: 8]});
      end else begin
         rd_q.push_back(v.exp);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ready_k = 0; rsp_k = 0; rsp_cnt = 0; wr_cnt = 0;
      for (int k = 1; k <= v.n + 4; k++) begin
         @(negedge clk);
         if (sb_wr_en) wr_cnt++;
         if (rsp_valid) begin rsp_cnt++; rsp_k = k; end
         if (cmd_ready && ready_k == 0) ready_k = k;
      end
      check("ready_latency", ready_k, v.wr ? v.n + 1 : v.n + 2);
      check("wr_en_cycles", wr_cnt, v.wr ? v.n : 0);
      check("rsp_pulses", rsp_cnt, v.wr ? 0 : 1);
      if (!v.wr)
         check("rsp_latency", rsp_k, v.n + 1);
      $display("txn %0d wr=%0d addr=%h data=%h mask=%b beats=%0d ready_k=%0d rsp_k=%0d rsp_data=%h",
               id, v.wr, v.addr, v.data, v.mask, v.n, ready_k, rsp_k, rsp_data);
   endtask

   initial begin
      vec_t rv;
      pmem[0] = 8'h78; pmem[1] = 8'h56; pmem[2] = 8'h34; pmem[3] = 8'h12;
      for (int i = 4; i < 8; i++) pmem[i] = 8'h00;

      vecs[0] = '{1'b1, 32'h4,    32'hDDCCBBAA, 4'b1111, 4, 32'h0};
      vecs[1] = '{1'b0, 32'h0,    32'h0,        4'b1111, 4, 32'h12345678};
      vecs[2] = '{1'b1, 32'h4,    32'h11223344, 4'b1010, 2, 32'h0};
      vecs[4] = '{1'b1, 32'h0,    32'hFFFFFFFF, 4'b0000, 0, 32'h0};
      vecs[8] = '{1'b1, 32'h0,    32'hA5A50F0F, 4'b1001, 2, 32'h0};
      vecs[9] = '{1'b0, 32'h0,    32'h0,        4'b1111, 4, 32'hA534560F};
`ifdef SIMP_BUS_RD_ALL_EN
      vecs[3] = '{1'b0, 32'h4,    32'h0,        4'b0100, 4, 32'h11CC33AA};
      vecs[5] = '{1'b0, 32'h0,    32'h0,        4'b0000, 4, 32'h12345678};
      vecs[6] = '{1'b0, 32'h4,    32'h0,        4'b1010, 4, 32'h11CC33AA};
      vecs[7] = '{1'b0, 32'h1003, 32'h0,        4'b0011, 4, 32'h12345678};
`else
      vecs[3] = '{1'b0, 32'h4,    32'h0,        4'b0100, 1, 32'h00CC0000};
      vecs[5] = '{1'b0, 32'h0,    32'h0,        4'b0000, 0, 32'h00000000};
      vecs[6] = '{1'b0, 32'h4,    32'h0,        4'b1010, 2, 32'h11003300};
      vecs[7] = '{1'b0, 32'h1003, 32'h0,        4'b0011, 2, 32'h00005678};
`endif

      // Reset state.
      #12;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_sb_wr_en",  {31'd0, sb_wr_en},  32'd0);
      check("rst_rsp_data",  rsp_data, 32'd0);
      check("rst_sb_adr",    {29'd0, sb_adr}, 32'd0);
      check("rst_sb_din",    {24'd0, sb_din}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++)
         run_cmd(i, vecs[i]);

      // Reset during beat 2 of a 4-byte write: only lane 0 reaches the peripheral.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0;
      cmd_data = 32'h44332211; cmd_mask = 4'b1111;
      wr_q.push_back({1'b0, 2'd0, 8'h11});
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_sb_wr_en",  {31'd0, sb_wr_en},  32'd0);
      check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("midrst_sb_adr",    {29'd0, sb_adr},    32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midrst_quiet", {30'd0, rsp_valid, sb_wr_en}, 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("postrst_idle", {29'd0, cmd_ready, rsp_valid, sb_wr_en}, 32'd4);
      end
      $display("txn reset-abort write addr=00000000 data=44332211 mask=1111");

      rv = '{1'b0, 32'h0, 32'h0, 4'b1111, 4, 32'hA5345611};
      run_cmd(10, rv);

      check("wr_q_empty", wr_q.size(), 0);
      check("rd_q_empty", rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
